// File: rtl/olvds_tx_ctrl.sv
// Serial frame controller feeding the A input of an OLVDS output buffer: start, LSB-first data, stop.
// Define OLVDS_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module olvds_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DVALID,
  output logic                  DREADY,
  output logic                  SER,
  output logic                  BUSY
);

  localparam int unsigned IdxW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [7:0]  Reload = 8'(BIT_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3
`ifdef OLVDS_TX_PARITY_EN
    , StPar = 3'd4
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            timer_q, timer_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  ser_q, ser_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  accept;
`ifdef OLVDS_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  always_comb begin
    bit_done = (timer_q == 8'd0);
    DREADY   = RSTN && ((state_q == StIdle) || ((state_q == StStop) && bit_done));
    accept   = DVALID && DREADY;

    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
`ifdef OLVDS_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StStart;
          timer_d  = Reload;
          shreg_d  = DIN;
`ifdef OLVDS_TX_PARITY_EN
          parity_d = ^DIN;
`endif
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          timer_d = Reload;
          idx_d   = '0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          timer_d = Reload;
          if (idx_q == LastIdx) begin
`ifdef OLVDS_TX_PARITY_EN
            state_d = StPar;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shreg_d = shreg_q >> 1;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
`ifdef OLVDS_TX_PARITY_EN
      StPar: begin
        if (bit_done) begin
          state_d = StStop;
          timer_d = Reload;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          // A word accepted in the last stop cycle starts the next frame with no gap.
          if (accept) begin
            state_d  = StStart;
            timer_d  = Reload;
            shreg_d  = DIN;
`ifdef OLVDS_TX_PARITY_EN
            parity_d = ^DIN;
`endif
          end else begin
            state_d = StIdle;
            timer_d = 8'd0;
          end
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // SER is registered from the next state so the line changes together with the state.
    unique case (state_d)
      StStart: ser_d = 1'b0;
      StData:  ser_d = shreg_d[0];
`ifdef OLVDS_TX_PARITY_EN
      StPar:   ser_d = parity_q;
`endif
      default: ser_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= StIdle;
      timer_q  <= 8'd0;
      idx_q    <= '0;
      shreg_q  <= '0;
      ser_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef OLVDS_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      ser_q    <= ser_d;
      busy_q   <= busy_d;
`ifdef OLVDS_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign SER  = ser_q;
  assign BUSY = busy_q;

endmodule
